// File: rtl/ft2232h_sync_fifo_emu_if.sv
// Signal bundle between the FT2232H sync-FIFO model and its users.
// The slave side is the USB-chip model; the master side is the FPGA logic and PC stimulus.
interface ft2232h_sync_fifo_emu_if #(
  parameter int DATA_W = 8
);
  logic              pc_wr_en_i;
  logic [DATA_W-1:0] pc_wr_data_i;
  logic              pc_rx_full_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_drive_o;
  logic              rxf_o;
  logic              oe_i;
  logic              rd_i;
  logic [DATA_W-1:0] tx_data_i;
  logic              wr_i;
  logic              txe_o;
  logic              pc_rd_en_i;
  logic [DATA_W-1:0] pc_rd_data_o;
  logic              pc_tx_empty_o;
  logic              rx_underrun_o;
  logic              tx_overflow_o;

  modport slave (
    input  pc_wr_en_i, pc_wr_data_i, oe_i, rd_i, tx_data_i, wr_i, pc_rd_en_i,
    output pc_rx_full_o, rx_data_o, rx_drive_o, rxf_o, txe_o,
           pc_rd_data_o, pc_tx_empty_o, rx_underrun_o, tx_overflow_o
  );

  modport master (
    output pc_wr_en_i, pc_wr_data_i, oe_i, rd_i, tx_data_i, wr_i, pc_rd_en_i,
    input  pc_rx_full_o, rx_data_o, rx_drive_o, rxf_o, txe_o,
           pc_rd_data_o, pc_tx_empty_o, rx_underrun_o, tx_overflow_o
  );
endinterface

// File: rtl/ft2232h_sync_fifo_emu.sv
// Cycle-accurate FT2232H 245 synchronous-FIFO mode model, FPGA-facing.
// RX: PC push -> FIFO -> RXF#/OE#/RD#.  TX: TXE#/WR# -> FIFO -> PC pop.
module ft2232h_sync_fifo_emu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic                     clk_i,
  input logic                     reset_i,
  ft2232h_sync_fifo_emu_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
  } fifo_state_t;

  function automatic fifo_state_t advance(input fifo_state_t s, input logic push, input logic pop);
    fifo_state_t n;
    n = s;
    if (push) n.wr_ptr = s.wr_ptr + ADDR_W'(1);
    if (pop)  n.rd_ptr = s.rd_ptr + ADDR_W'(1);
    if (push && !pop)      n.cnt = s.cnt + (ADDR_W+1)'(1);
    else if (pop && !push) n.cnt = s.cnt - (ADDR_W+1)'(1);
    return n;
  endfunction

  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [DATA_W-1:0] tx_mem [DEPTH];
  fifo_state_t       rx_st, tx_st;
  logic              ready;
  logic              rx_underrun, tx_overflow;

  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic rx_underrun_set, tx_overflow_set;

  assign rx_full  = (rx_st.cnt == FULL_CNT);
  assign rx_empty = (rx_st.cnt == '0);
  assign tx_full  = (tx_st.cnt == FULL_CNT);
  assign tx_empty = (tx_st.cnt == '0);

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
    rx_push         = 1'b0;
    rx_pop          = 1'b0;
    tx_push         = 1'b0;
    tx_pop          = 1'b0;
    rx_underrun_set = 1'b0;
    tx_overflow_set = 1'b0;
    if (reset_i) begin
      rx_push         = bus.pc_wr_en_i && !rx_full;
      rx_pop          = !bus.oe_i && !bus.rd_i && !rx_empty;
      rx_underrun_set = !bus.oe_i && !bus.rd_i && rx_empty;
      // WR# while not yet ready is ignored without flagging overflow.
      tx_push         = !bus.wr_i && ready && !tx_full;
      tx_overflow_set = !bus.wr_i && ready && tx_full;
      tx_pop          = bus.pc_rd_en_i && !tx_empty;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rx_st       <= '0;
      tx_st       <= '0;
      ready       <= 1'b0;
      rx_underrun <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      rx_st <= advance(rx_st, rx_push, rx_pop);
      tx_st <= advance(tx_st, tx_push, tx_pop);
      ready <= 1'b1;
      if (rx_underrun_set) rx_underrun <= 1'b1;
      if (tx_overflow_set) tx_overflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and counts alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_st.wr_ptr] <= bus.pc_wr_data_i;
    if (tx_push) tx_mem[tx_st.wr_ptr] <= bus.tx_data_i;
  end

  // Status outputs are forced to their idle values while reset is held.
  assign bus.rxf_o         = !reset_i || rx_empty;
  assign bus.pc_rx_full_o  = reset_i && rx_full;
  assign bus.rx_drive_o    = !bus.oe_i;
  assign bus.rx_data_o     = bus.oe_i ? '0 : rx_mem[rx_st.rd_ptr];
  assign bus.txe_o         = !(reset_i && ready && !tx_full);
  assign bus.pc_tx_empty_o = !reset_i || tx_empty;
  assign bus.pc_rd_data_o  = tx_mem[tx_st.rd_ptr];
  assign bus.rx_underrun_o = rx_underrun;
  assign bus.tx_overflow_o = tx_overflow;
endmodule

// File: tb/tb_ft2232h_sync_fifo_emu.sv
// Scoreboard bench for the FT2232H sync-FIFO model: directed phases plus random traffic,
// checked against queue-based models of the RX and TX FIFOs.
module tb_ft2232h_sync_fifo_emu;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ft2232h_sync_fifo_emu_if #(.DATA_W(DW)) bus ();

  ft2232h_sync_fifo_emu #(.DATA_W(DW), .ADDR_W(4)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  // Model state: queue contents are the FIFO contents before the next edge plus
  // at most one pending entry (pend_*) that the driver committed for that edge.
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] tx_q[$];
  int  pend_rx = 0, pend_tx = 0;
  bit  exp_ready = 1'b0, exp_underrun = 1'b0, exp_overflow = 1'b0;
  int  total = 0, bad = 0;
  bit  running = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.pc_wr_en_i = 1'b0;
    bus.oe_i       = 1'b1;
    bus.rd_i       = 1'b1;
    bus.wr_i       = 1'b1;
    bus.pc_rd_en_i = 1'b0;
  endtask

  // Commit accepted stimulus to the model, then advance one clock.
  task automatic tick();
    if (rst_n && bus.pc_wr_en_i && rx_q.size() < DEPTH) begin
      rx_q.push_back(bus.pc_wr_data_i);
      pend_rx = 1;
    end
    if (rst_n && !bus.wr_i && exp_ready && tx_q.size() < DEPTH) begin
      tx_q.push_back(bus.tx_data_i);
      pend_tx = 1;
    end
    @(posedge clk);
    #1;
    pend_rx = 0;
    pend_tx = 0;
  endtask

  task automatic pc_push(input logic [DW-1:0] d);
    bus.pc_wr_en_i   = 1'b1;
    bus.pc_wr_data_i = d;
    tick();
    bus.pc_wr_en_i   = 1'b0;
  endtask

  // Monitor: compares outputs mid-cycle against the model, then retires this edge's pops.
  always @(negedge clk) begin
    int rx_n, tx_n;
    logic [DW-1:0] w;
    if (running) begin
      rx_n = rx_q.size() - pend_rx;
      tx_n = tx_q.size() - pend_tx;
      check("rx_drive", bus.rx_drive_o, !bus.oe_i);
      if (bus.oe_i) check("rx_data_idle", bus.rx_data_o, 0);
      if (!rst_n) begin
        check("rst_rxf", bus.rxf_o, 1);
        check("rst_txe", bus.txe_o, 1);
        check("rst_rx_full", bus.pc_rx_full_o, 0);
        check("rst_tx_empty", bus.pc_tx_empty_o, 1);
        rx_q.delete();
        tx_q.delete();
        exp_ready    = 1'b0;
        exp_underrun = 1'b0;
        exp_overflow = 1'b0;
      end else begin
        check("rxf", bus.rxf_o, rx_n == 0);
        check("rx_full", bus.pc_rx_full_o, rx_n == DEPTH);
        check("txe", bus.txe_o, !(exp_ready && tx_n < DEPTH));
        check("tx_empty", bus.pc_tx_empty_o, tx_n == 0);
        check("underrun", bus.rx_underrun_o, exp_underrun);
        check("overflow", bus.tx_overflow_o, exp_overflow);
        if (!bus.oe_i && rx_n > 0) begin
          if (!bus.rd_i) begin
            w = rx_q.pop_front();
            check("rx_pop_data", bus.rx_data_o, w);
          end else begin
            check("rx_head", bus.rx_data_o, rx_q[0]);
          end
        end else if (!bus.oe_i && !bus.rd_i) begin
          exp_underrun = 1'b1;
        end
        if (tx_n > 0) begin
          if (bus.pc_rd_en_i) begin
            w = tx_q.pop_front();
            check("tx_pop_data", bus.pc_rd_data_o, w);
          end else begin
            check("tx_head", bus.pc_rd_data_o, tx_q[0]);
          end
        end
        if (!bus.wr_i && exp_ready && tx_n == DEPTH) exp_overflow = 1'b1;
        exp_ready = 1'b1;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    bus.pc_wr_data_i = '0;
    bus.tx_data_i    = '0;

    // Reset, release, idle.
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // RX burst: three words, OE# alone first, then three back-to-back reads.
    pc_push(8'h11);
    pc_push(8'h22);
    pc_push(8'h33);
    bus.oe_i = 1'b0;
    tick();
    bus.rd_i = 1'b0;
    repeat (3) tick();
    set_idle();
    repeat (2) tick();

    // RD# with OE# high is ignored; then a real pop, then a pop while empty.
    pc_push(8'h44);
    bus.rd_i = 1'b0;
    tick();
    bus.oe_i = 1'b0;
    repeat (2) tick();
    set_idle();
    tick();

    // Overfill RX with 17 words, then drain it.
    for (int i = 0; i < 17; i++) pc_push(8'(8'h80 + i));
    tick();
    bus.oe_i = 1'b0;
    bus.rd_i = 1'b0;
    repeat (17) tick();
    set_idle();
    tick();

    // TX fill with 17 writes, then drain.
    bus.wr_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.tx_data_i = 8'(i);
      tick();
    end
    set_idle();
    tick();
    bus.pc_rd_en_i = 1'b1;
    repeat (17) tick();
    set_idle();
    tick();

    // Clear sticky flags, then hold both FIFOs at 8 entries across pointer wrap.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      bus.pc_wr_en_i   = 1'b1;
      bus.pc_wr_data_i = 8'($urandom);
      bus.wr_i         = 1'b0;
      bus.tx_data_i    = 8'($urandom);
      tick();
    end
    bus.oe_i       = 1'b0;
    bus.rd_i       = 1'b0;
    bus.pc_rd_en_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.pc_wr_data_i = 8'($urandom);
      bus.tx_data_i    = 8'($urandom);
      tick();
    end
    set_idle();
    tick();

    // Reset during an active RX read, then a fresh word survives.
    bus.oe_i = 1'b0;
    bus.rd_i = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_idle();
    tick();
    pc_push(8'h5A);
    bus.oe_i = 1'b0;
    bus.rd_i = 1'b0;
    tick();
    set_idle();
    repeat (2) tick();

    // Random traffic in alternating fill-biased and drain-biased segments.
    for (int seg = 0; seg < 8; seg++) begin
      for (int i = 0; i < 50; i++) begin
        rst_n            = ($urandom_range(99) != 0);
        bus.pc_wr_en_i   = (seg % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
        bus.pc_wr_data_i = 8'($urandom);
        bus.oe_i         = ($urandom_range(3) == 0);
        bus.rd_i         = (seg % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
        bus.wr_i         = (seg % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
        bus.tx_data_i    = 8'($urandom);
        bus.pc_rd_en_i   = (seg % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
        tick();
      end
    end
    rst_n = 1'b1;
    set_idle();
    repeat (2) tick();

    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ft2232h_sync_fifo_emu.md
Name: ft2232h_sync_fifo_emu

Overview:
- Synthesizable, cycle-accurate model of the FT2232H in 245 synchronous-FIFO mode, seen from the FPGA side.
- RX path (PC to FPGA): a PC-side push port fills an internal RX FIFO, which the FPGA drains through the RXF#/OE#/RD# handshake.
- TX path (FPGA to PC): the FPGA fills an internal TX FIFO through the TXE#/WR# handshake, and a PC-side pop port drains it.
- Used as the USB-chip stand-in in simulation, and as a loopback target for the FPGA interface logic.

Parameters:
- DATA_W, 8, bus width.
- ADDR_W, 4, log2 depth of each FIFO (16 entries each).

Ports:
- clk_i  in  1  single clock (the 60 MHz CLKOUT domain); every port is synchronous to its rising edge.
- reset_i  in  1  reset, synchronous and active-low.
- pc_wr_en_i  in  1  PC push request into the RX FIFO.
- pc_wr_data_i  in  DATA_W  PC push data.
- pc_rx_full_o  out  1  RX FIFO full.
- rx_data_o  out  DATA_W  RX head word, driven toward the FPGA.
- rx_drive_o  out  1  bus-drive enable, equal to !oe_i; the parent tristates the inout bus with it.
- rxf_o  out  1  active-low: RX data available.
- oe_i  in  1  active-low output enable from the FPGA.
- rd_i  in  1  active-low read strobe from the FPGA.
- tx_data_i  in  DATA_W  FPGA write data.
- wr_i  in  1  active-low write strobe from the FPGA.
- txe_o  out  1  active-low: TX FIFO can accept data.
- pc_rd_en_i  in  1  PC pop request from the TX FIFO.
- pc_rd_data_o  out  DATA_W  TX head word (show-ahead).
- pc_tx_empty_o  out  1  TX FIFO empty.
- rx_underrun_o  out  1  sticky: RD# accepted while RX FIFO empty.
- tx_overflow_o  out  1  sticky: WR# asserted while TX FIFO full.

Behaviour:
- Each FIFO is a circular buffer: memory, ADDR_W-bit read/write pointers, and an (ADDR_W+1)-bit count. Pointers wrap from 2^ADDR_W-1 to 0.
- Full means count == 2^ADDR_W. Empty means count == 0.
- All full/empty decisions use the pre-edge state.

Reset (reset_i == 0 at a rising edge):
- Pointers and counts clear, sticky flags clear, ready register clears.
- Memory contents are not cleared.
- Outputs while in reset: rxf_o = 1, txe_o = 1, pc_rx_full_o = 0, pc_tx_empty_o = 1.
- Reset mid-transfer discards all queued data.

RX push:
- If pc_wr_en_i && !full: write pc_wr_data_i at the write pointer, increment the pointer.
- If full: the push is dropped, with no state change, even when a pop occurs in the same cycle.

RX pop:
- rxf_o = empty, combinational from count.
- rx_data_o = mem[rd_ptr] when oe_i == 0, else 0. Show-ahead: the head word is visible as soon as OE# falls, with zero latency.
- A pop occurs on a rising edge where oe_i == 0, rd_i == 0 and rxf_o == 0. One word is consumed per clock while RD# stays low, so back-to-back bursts run at 1 word/cycle.
- rd_i low with oe_i high: ignored.
- rd_i low and oe_i low while empty: no pop; rx_underrun_o sets.
- Simultaneous push and pop (not full, not empty): both happen, count unchanged.
- A pop that empties the FIFO raises rxf_o on the following cycle (count-based).

TX ready:
- A ready register is cleared by reset and set one cycle after reset_i returns high.
- txe_o = !(ready && !full).

TX write:
- On an edge with wr_i == 0 && txe_o == 0: capture tx_data_i, increment the write pointer.
- wr_i low while full: data dropped; tx_overflow_o sets.
- wr_i low while txe_o is high because of the ready register: silently ignored, and the flag does not set.

TX pop:
- pc_rd_data_o = mem[rd_ptr], show-ahead.
- A pop occurs when pc_rd_en_i && !empty; a pop request while empty is ignored.
- Simultaneous write and pop: both happen.
- A write into an empty FIFO becomes visible on pc_rd_data_o, and pc_tx_empty_o falls, the cycle after the edge.

Test Plan:
1. Reset then idle: hold reset_i low for 3 clocks -> rxf_o = 1, txe_o = 1, pc_tx_empty_o = 1. Release reset -> txe_o = 0 after exactly 1 clock; rxf_o stays 1.
2. RX burst: push 0x11, 0x22, 0x33; OE# low one cycle, then RD# low for 3 cycles -> rx_data_o shows 0x11 with OE# alone, then 0x11/0x22/0x33 at successive edges; rxf_o = 1 after the third pop; rx_underrun_o = 0.
3. RX edge cases: RD# low with OE# high while 0x44 is queued -> nothing popped, rx_data_o = 0, rx_drive_o = 0. Pop with the FIFO empty -> rx_underrun_o = 1. Push 17 words -> the 17th is dropped and pc_rx_full_o = 1.
4. TX fill and overflow: WR# low for 17 cycles with data 0x00..0x10 -> txe_o = 1 after the 16th write; 0x10 is dropped; tx_overflow_o = 1. Drain via pc_rd_en_i -> 0x00..0x0F in order, then pc_tx_empty_o = 1.
5. Simultaneity and wrap: keep each FIFO at count 8 with a concurrent push and pop for 40 cycles -> count stays at 8, data order is preserved across pointer wrap, and no flags set.
6. Reset mid-burst: assert reset_i during an active RX read -> next cycle rxf_o = 1 and the queued words are lost; a new push of 0x5A reads back as 0x5A.
